// File: rtl/tnn_popcount_sched.sv
// tnn_popcount_sched: time-multiplexes one shared 27-input popcount unit
// over the positive and negative weight chunks of a ternary neuron,
// accumulates (pos - neg) and thresholds the result.
module tnn_popcount_sched #(
  parameter int unsigned CHUNKS = 4,
  parameter int unsigned ACC_W  = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [27*CHUNKS-1:0]    in_pos,
  input  logic [27*CHUNKS-1:0]    in_neg,
  input  logic signed [ACC_W-1:0] in_thr,
  output logic [26:0]             pc_in,
  input  logic [4:0]              pc_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_act,
  output logic                    busy
);

  localparam int unsigned FW    = 27 * CHUNKS;
  localparam int unsigned IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, POS, NEG, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [FW-1:0]           pos_q, pos_d;
  logic [FW-1:0]           neg_q, neg_d;
  logic signed [ACC_W-1:0] thr_q, thr_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic                    act_q, act_d;

  logic [26:0]             pos_chunk, neg_chunk;
  logic signed [ACC_W-1:0] pc_ext;

  // Popcount result is an opaque unsigned 0..31, zero-extended into the accumulator.
  assign pc_ext = {{(ACC_W-5){1'b0}}, pc_out};

  assign busy    = (state_q != IDLE);
  assign out_sum = sum_q;
  assign out_act = act_q;

  // Select the current 27-bit chunk of the latched pos/neg masks.
  always_comb begin
    pos_chunk = '0;
    neg_chunk = '0;
    for (int unsigned k = 0; k < CHUNKS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        pos_chunk = pos_q[27*k +: 27];
        neg_chunk = neg_q[27*k +: 27];
      end
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    pos_d     = pos_q;
    neg_d     = neg_q;
    thr_d     = thr_q;
    sum_d     = sum_q;
    act_d     = act_q;
    pc_in     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pos_d   = in_pos;
          neg_d   = in_neg;
          thr_d   = in_thr;
          idx_d   = '0;
          acc_d   = '0;
          state_d = POS;
        end
      end
      POS: begin
        pc_in = pos_chunk;
        acc_d = acc_q + pc_ext;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = NEG;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      NEG: begin
        pc_in = neg_chunk;
        acc_d = acc_q - pc_ext;
        if (idx_q == IDX_LAST) begin
          sum_d   = acc_d;
          act_d   = (acc_d >= thr_q);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      acc_q <= '0;
      pos_q <= '0;
      neg_q <= '0;
      thr_q <= '0;
      sum_q <= '0;
      act_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
      pos_q <= pos_d;
      neg_q <= neg_d;
      thr_q <= thr_d;
      sum_q <= sum_d;
      act_q <= act_d;
    end
  end

endmodule

// File: tb/tb_tnn_popcount_sched.sv
// Directed testbench for tnn_popcount_sched (CHUNKS=4, ACC_W=9).
module tb_tnn_popcount_sched;

  localparam int unsigned CH = 4;
  localparam int unsigned AW = 9;
  localparam int unsigned FW = 27 * CH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_pos, in_neg;
  logic [AW-1:0] in_thr;
  logic [26:0]   pc_in;
  logic [4:0]    pc_out;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_act;
  logic          busy;
  logic          stub_mode = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Shared popcount unit model: exact, or a stub that over-reports 31 for any nonzero operand.
  always_comb begin
    if (stub_mode) pc_out = (pc_in != '0) ? 5'd31 : 5'd0;
    else           pc_out = 5'($countones(pc_in));
  end

  tnn_popcount_sched #(.CHUNKS(CH), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .in_thr(in_thr),
    .pc_in(pc_in), .pc_out(pc_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_act(out_act), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] chunk_of(input logic [FW-1:0] v, input int k);
    logic [FW-1:0] t;
    t = v >> (27 * k);
    return t[26:0];
  endfunction

  // One full job starting from IDLE at a negedge; returns at a negedge back in IDLE.
  task automatic run_job(input string tag, input logic [FW-1:0] p, input logic [FW-1:0] n,
                         input logic [AW-1:0] thr, input logic [AW-1:0] es, input logic ea,
                         input int hold);
    @(negedge clk);
    in_pos = p; in_neg = n; in_thr = thr; in_valid = 1'b1;
    check_eq({tag, "_ready_idle"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_pos = ~p; in_neg = ~n; in_thr = ~thr;
    for (int c = 0; c < 2 * CH; c++) begin
      @(negedge clk);
      check_eq({tag, "_pc_in"}, pc_in, (c < CH) ? chunk_of(p, c) : chunk_of(n, c - CH));
      check_eq({tag, "_valid_low"}, out_valid, 0);
      check_eq({tag, "_ready_busy"}, in_ready, 0);
    end
    @(negedge clk);
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_sum"}, out_sum, es);
    check_eq({tag, "_act"}, out_act, ea);
    check_eq({tag, "_pc_done"}, pc_in, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_pos = p ^ {FW{h[0]}}; in_thr = thr + 9'd1;
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_sum"}, out_sum, es);
      check_eq({tag, "_hold_act"}, out_act, ea);
      check_eq({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_ret_ready"}, in_ready, 1);
    check_eq({tag, "_ret_valid"}, out_valid, 0);
    check_eq({tag, "_ret_busy"}, busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [FW-1:0] p, n;
    int last, ndone;

    rst = 1'b1; in_valid = 1'b1; in_pos = '1; in_neg = '0; in_thr = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_sum", out_sum, 0);
    check_eq("rst_act", out_act, 0);
    check_eq("rst_pc_in", pc_in, 0);
    in_valid = 1'b0;
    rst = 1'b0;

    // All positive ones, backpressure held for 5 cycles in DONE.
    run_job("pos_all", '1, '0, 9'd100, 9'd108, 1'b1, 5);
    // All negative ones: -108.
    run_job("neg_all", '0, '1, 9'd0, 9'h194, 1'b0, 0);
    // 50 vs 50 bits: tie with threshold gives act=1.
    p = (108'd1 << 50) - 108'd1;
    n = p << 58;
    run_job("tie", p, n, 9'd0, 9'd0, 1'b1, 0);
    // Distinct chunk patterns: pos 1+2+3+4, neg 0+1+0+7 -> 2, below thr 3.
    p = {27'h000000F, 27'h0000007, 27'h0000003, 27'h0000001};
    n = {27'h000007F, 27'h0000000, 27'h0000100, 27'h0000000};
    run_job("chunks", p, n, 9'd3, 9'd2, 1'b0, 0);

    // Reset in the third POS cycle aborts the job asynchronously.
    @(negedge clk);
    in_pos = '1; in_neg = '0; in_thr = '0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("mid_busy", busy, 1);
    check_eq("mid_pc_in", pc_in, 27'h7FFFFFF);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", in_ready, 1);
    check_eq("abort_pc_in", pc_in, 0);
    check_eq("abort_sum", out_sum, 0);
    check_eq("abort_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    run_job("after_rst", {81'd0, 27'h7FFFFFF}, '0, 9'd27, 9'd27, 1'b1, 0);

    // Over-reporting stub, back-to-back with out_ready tied high.
    stub_mode = 1'b1;
    in_pos = '1; in_neg = '0; in_thr = 9'd124; in_valid = 1'b1; out_ready = 1'b1;
    last = -1; ndone = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        check_eq("b2b_sum", out_sum, 9'd124);
        check_eq("b2b_act", out_act, 1);
        if (last >= 0) check_eq("b2b_period", cyc - last, 10);
        last = cyc;
        ndone++;
      end
    end
    check_eq("b2b_count", (ndone >= 4) ? 1 : 0, 1);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
